// File: rtl/seg_display_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : seg_display_scanner
//  Description : Captures four 2x2 result words on a load pulse and scans
//                them as 8 hex digits onto a common-anode 7-segment display.
//                Digit select and segments are both active-low.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg_display_scanner #(
  parameter int DATA_W      = 8,
  parameter int REFRESH_DIV = 4,
  parameter int DP_EN       = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              load,
  input  logic [DATA_W-1:0] C11,
  input  logic [DATA_W-1:0] C12,
  input  logic [DATA_W-1:0] C21,
  input  logic [DATA_W-1:0] C22,
  output logic [7:0]        digit,
  output logic [7:0]        segment_data,
  output logic              busy,
  output logic              frame_done
);

  localparam int c_CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(REFRESH_DIV - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [2:0]           r_idx;
  logic [2:0]           w_idx_nxt;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [c_CNT_W-1:0]   w_cnt_nxt;
  logic                 w_capture;
  logic                 w_term;

  logic [7:0]           r_c11, r_c12, r_c21, r_c22;
  logic [7:0]           w_in11, w_in12, w_in21, w_in22;

  logic [7:0]           r_digit, r_seg;
  logic                 r_busy, r_fd;
  logic [7:0]           w_digit_nxt, w_seg_nxt;
  logic                 w_busy_nxt, w_fd_nxt;
  logic [3:0]           w_nib;

  // Active-low hex segment decode, dp (bit 7) off.
  function automatic logic [7:0] hex7(input logic [3:0] n);
    logic [7:0] s;
    case (n)
      4'h0: s = 8'hC0;  4'h1: s = 8'hF9;  4'h2: s = 8'hA4;  4'h3: s = 8'hB0;
      4'h4: s = 8'h99;  4'h5: s = 8'h92;  4'h6: s = 8'h82;  4'h7: s = 8'hF8;
      4'h8: s = 8'h80;  4'h9: s = 8'h90;  4'hA: s = 8'h88;  4'hB: s = 8'h83;
      4'hC: s = 8'hC6;  4'hD: s = 8'hA1;  4'hE: s = 8'h86;  default: s = 8'h8E;
    endcase
    return s;
  endfunction

  // Zero-extend the result words to a full byte (two hex digits each).
  always_comb begin
    w_in11 = '0;
    w_in12 = '0;
    w_in21 = '0;
    w_in22 = '0;
    w_in11[DATA_W-1:0] = C11;
    w_in12[DATA_W-1:0] = C12;
    w_in21[DATA_W-1:0] = C21;
    w_in22[DATA_W-1:0] = C22;
  end

  assign w_term = (r_cnt == c_CNT_MAX);

  // Next-state: load restarts the frame at idx 7; dropping enable parks in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        if (enable) begin
          w_state_nxt = SCAN;
          w_idx_nxt   = 3'd7;
          w_cnt_nxt   = '0;
          w_capture   = load;
        end
      end
      SCAN: begin
        if (!enable) begin
          w_state_nxt = IDLE;
          w_idx_nxt   = 3'd7;
          w_cnt_nxt   = '0;
        end else if (load) begin
          w_capture   = 1'b1;
          w_idx_nxt   = 3'd7;
          w_cnt_nxt   = '0;
        end else if (w_term) begin
          w_cnt_nxt   = '0;
          w_idx_nxt   = r_idx - 3'd1;  // 0 wraps naturally to 7
        end else begin
          w_cnt_nxt   = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output decode from the current state; registered one stage below.
  always_comb begin
    w_digit_nxt = 8'hFF;
    w_seg_nxt   = 8'hFF;
    w_busy_nxt  = 1'b0;
    w_fd_nxt    = 1'b0;
    w_nib       = 4'h0;
    case (r_idx)
      3'd7:    w_nib = r_c11[7:4];
      3'd6:    w_nib = r_c11[3:0];
      3'd5:    w_nib = r_c12[7:4];
      3'd4:    w_nib = r_c12[3:0];
      3'd3:    w_nib = r_c21[7:4];
      3'd2:    w_nib = r_c21[3:0];
      3'd1:    w_nib = r_c22[7:4];
      default: w_nib = r_c22[3:0];
    endcase
    if (r_state == SCAN) begin
      w_digit_nxt = ~(8'b1 << r_idx);
      w_seg_nxt   = hex7(w_nib);
      if ((DP_EN != 0) && ((r_idx == 3'd6) || (r_idx == 3'd4) || (r_idx == 3'd2)))
        w_seg_nxt[7] = 1'b0;
      w_busy_nxt  = 1'b1;
      // A reload at the frame end restarts the frame, so it is not "done".
      w_fd_nxt    = w_term && (r_idx == 3'd0) && !(enable && load);
    end
  end

  // State, captured words and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_idx   <= 3'd7;
      r_cnt   <= '0;
      r_c11   <= '0;
      r_c12   <= '0;
      r_c21   <= '0;
      r_c22   <= '0;
      r_digit <= 8'hFF;
      r_seg   <= 8'hFF;
      r_busy  <= 1'b0;
      r_fd    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_capture) begin
        r_c11 <= w_in11;
        r_c12 <= w_in12;
        r_c21 <= w_in21;
        r_c22 <= w_in22;
      end
      r_digit <= w_digit_nxt;
      r_seg   <= w_seg_nxt;
      r_busy  <= w_busy_nxt;
      r_fd    <= w_fd_nxt;
    end
  end

  assign digit        = r_digit;
  assign segment_data = r_seg;
  assign busy         = r_busy;
  assign frame_done   = r_fd;

endmodule
`default_nettype wire

// File: tb/tb_seg_display_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg_display_scanner
//  Description : Scoreboard bench for seg_display_scanner (DP_EN=0 and =1
//                instances sharing stimulus) against a frame-position model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_display_scanner;

  localparam int RD    = 4;
  localparam int FRAME = 8 * RD;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b0;
  logic       load = 1'b0;
  logic [7:0] c11 = 8'h00, c12 = 8'h00, c21 = 8'h00, c22 = 8'h00;
  logic [7:0] dig0, seg0, dig1, seg1;
  logic       busy0, fd0, busy1, fd1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  seg_display_scanner #(.DATA_W(8), .REFRESH_DIV(RD), .DP_EN(0)) dut0 (
    .clk(clk), .rst(rst), .enable(enable), .load(load),
    .C11(c11), .C12(c12), .C21(c21), .C22(c22),
    .digit(dig0), .segment_data(seg0), .busy(busy0), .frame_done(fd0));

  seg_display_scanner #(.DATA_W(8), .REFRESH_DIV(RD), .DP_EN(1)) dut1 (
    .clk(clk), .rst(rst), .enable(enable), .load(load),
    .C11(c11), .C12(c12), .C21(c21), .C22(c22),
    .digit(dig1), .segment_data(seg1), .busy(busy1), .frame_done(fd1));

  logic [7:0] hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // Reference model: words, active flag, and cycle position inside the frame.
  logic [7:0] m_w [4];
  bit         m_act = 1'b0;
  int         m_pos = 0;

  logic [17:0] q0 [$];
  logic [17:0] q1 [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [17:0] expect_out(input bit dp);
    int         idx;
    logic [7:0] w;
    logic [3:0] nib;
    logic [7:0] s;
    logic [7:0] d;
    bit         fd;
    if (!m_act) return {8'hFF, 8'hFF, 1'b0, 1'b0};
    idx = 7 - m_pos / RD;
    w   = m_w[(7 - idx) / 2];
    nib = (idx % 2 == 1) ? w[7:4] : w[3:0];
    s   = hex_tab[nib];
    if (dp && (idx == 6 || idx == 4 || idx == 2)) s[7] = 1'b0;
    d   = 8'hFF;
    d[idx] = 1'b0;
    fd  = (m_pos == FRAME - 1) && !(enable && load);
    return {d, s, 1'b1, fd};
  endfunction

  // Model: predict the output that follows this edge, then advance.
  always @(posedge clk) begin
    if (!rst) begin
      q0.push_back({8'hFF, 8'hFF, 1'b0, 1'b0});
      q1.push_back({8'hFF, 8'hFF, 1'b0, 1'b0});
      for (int i = 0; i < 4; i++) m_w[i] = 8'h00;
      m_act = 1'b0;
      m_pos = 0;
    end else begin
      q0.push_back(expect_out(1'b0));
      q1.push_back(expect_out(1'b1));
      if (enable && load) begin
        m_w[0] = c11; m_w[1] = c12; m_w[2] = c21; m_w[3] = c22;
        m_act = 1'b1;
        m_pos = 0;
      end else if (!enable) begin
        m_act = 1'b0;
        m_pos = 0;
      end else if (!m_act) begin
        m_act = 1'b1;
        m_pos = 0;
      end else begin
        m_pos = (m_pos + 1) % FRAME;
      end
    end
  end

  // Monitor: compare every cycle, mid-period.
  always @(negedge clk) begin
    if (q0.size() > 0) chk("dut0_out", 32'({dig0, seg0, busy0, fd0}), 32'(q0.pop_front()));
    if (q1.size() > 0) chk("dut1_dp_out", 32'({dig1, seg1, busy1, fd1}), 32'(q1.pop_front()));
  end

  task automatic wait_digit(input logic [7:0] d);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (dig0 == d) begin
        chk("wait_digit", 32'(dig0), 32'(d));
        return;
      end
    end
    chk("wait_digit_timeout", 32'(dig0), 32'(d));
  endtask

  logic [7:0] t_dig [8] = '{8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE};
  logic [7:0] t_seg [8] = '{8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h88, 8'h83, 8'hC0, 8'h8E};

  initial begin
    // Reset held two cycles, then idle with enable low.
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);

    // Scan of a known word set, checked against a literal sequence too.
    c11 = 8'h12; c12 = 8'h34; c21 = 8'hAB; c22 = 8'h0F;
    enable = 1'b1; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    for (int d = 0; d < 8; d++) begin
      for (int c = 0; c < RD; c++) begin
        @(negedge clk);
        chk("seq_digit", 32'(dig0), 32'(t_dig[d]));
        chk("seq_seg", 32'(seg0), 32'(t_seg[d]));
        chk("seq_fd", 32'(fd0), 32'((d == 7) && (c == RD - 1)));
      end
    end
    @(negedge clk);
    chk("wrap_digit", 32'({dig0, seg0, fd0}), 32'({8'h7F, 8'hF9, 1'b0}));

    // Disable mid-scan, then resume without load.
    wait_digit(8'hEF);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    enable = 1'b1;
    repeat (10) @(negedge clk);

    // Reload mid-frame at idx 3.
    wait_digit(8'hF7);
    c11 = 8'hFF; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    c11 = 8'($urandom);
    repeat (40) @(negedge clk);

    // All-zero words: exercises the decimal-point instance.
    c11 = 8'h00; c12 = 8'h00; c21 = 8'h00; c22 = 8'h00;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (40) @(negedge clk);

    // Reset mid-scan, then re-enable without load.
    c11 = 8'h5A; c12 = 8'hC3; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      rst    = ($urandom_range(0, 199) != 0);
      enable = ($urandom_range(0, 9) != 0);
      load   = ($urandom_range(0, 15) == 0);
      c11 = 8'($urandom); c12 = 8'($urandom);
      c21 = 8'($urandom); c22 = 8'($urandom);
      @(negedge clk);
    end
    rst = 1'b1; load = 1'b0;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
